// File: rtl/gpioemu_pkg.sv
// Shared constants for the gpioemu sequential multiplier: register offsets,
// status bit positions and FSM state encoding.
package gpioemu_pkg;

  // Register offsets relative to the block base address
  localparam int unsigned OFF_A1 = 'h08;
  localparam int unsigned OFF_A2 = 'h10;
  localparam int unsigned OFF_W  = 'h18;
  localparam int unsigned OFF_L  = 'h20;
  localparam int unsigned OFF_B  = 'h28;
  localparam int unsigned OFF_G  = 'h30;

  // Status register (B) bit positions
  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_OVF  = 2;
  localparam int unsigned ST_COLL = 3;

  // Top-level FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_POP  = 2'd2;

endpackage

// File: rtl/gpioemu_shiftmul.sv
// Shift-add multiplier: consumes one multiplier bit per cycle for OP_W cycles
// and pulses valid for one cycle when prod holds the final product.
module gpioemu_shiftmul #(
  parameter int unsigned OP_W = 24
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                start,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic                busy,
  output logic [2*OP_W-1:0]   prod,
  output logic                valid
);

  localparam int unsigned PW    = 2 * OP_W;
  localparam int unsigned CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;

  logic [PW-1:0]    mcand;
  logic [OP_W-1:0]  mplier;
  logic [CNT_W-1:0] cnt;

  // Load operands on start, then add the shifted multiplicand per set multiplier bit
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      prod   <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start && !busy) begin
        mcand  <= PW'(a);
        mplier <= b;
        prod   <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) begin
          prod <= prod + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(OP_W - 1)) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpioemu_seqmul.sv
// gpioemu multiplier peripheral: bus decode with edge-detected strobes,
// operand/result registers, multiply then bit-serial popcount, status and gpio.
module gpioemu_seqmul
  import gpioemu_pkg::*;
#(
  parameter int unsigned OP_W   = 24,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned BASE   = 'h0100,
  parameter int unsigned GPIO_W = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [ADDR_W-1:0] saddress,
  input  logic              srd,
  input  logic              swr,
  input  logic [DATA_W-1:0] sdata_in,
  output logic [DATA_W-1:0] sdata_out,
  input  logic [GPIO_W-1:0] gpio_in,
  input  logic              gpio_latch,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_in_s_insp
);

  localparam int unsigned PW    = 2 * OP_W;
  localparam int unsigned EXT_W = (PW > DATA_W) ? PW : DATA_W;
  localparam int unsigned POP_W = $clog2(DATA_W + 1);
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [1:0]        state, state_next;
  logic              srd_q, swr_q;
  logic [OP_W-1:0]   a1_q, a2_q;
  logic [DATA_W-1:0] w_q, l_q, w_work, w_shift;
  logic [POP_W-1:0]  pop_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic              done_q, ovf_q, coll_q;

  logic              mul_busy, mul_valid;
  logic [PW-1:0]     prod;
  logic [EXT_W-1:0]  prod_ext_c;
  logic [DATA_W-1:0] w_new_c, status_c, rd_data_c;
  logic              ovf_new_c;
  logic              wr_fire_c, rd_fire_c, busy_c, start_c, coll_set_c, pop_last_c;
  logic              hit_a1_c, hit_a2_c, hit_w_c, hit_l_c, hit_b_c, hit_g_c;
  logic              unused_hi_c;

  assign wr_fire_c = swr && !swr_q;
  assign rd_fire_c = srd && !srd_q && !wr_fire_c;

  assign hit_a1_c = (saddress == ADDR_W'(BASE + OFF_A1));
  assign hit_a2_c = (saddress == ADDR_W'(BASE + OFF_A2));
  assign hit_w_c  = (saddress == ADDR_W'(BASE + OFF_W));
  assign hit_l_c  = (saddress == ADDR_W'(BASE + OFF_L));
  assign hit_b_c  = (saddress == ADDR_W'(BASE + OFF_B));
  assign hit_g_c  = (saddress == ADDR_W'(BASE + OFF_G));

  assign busy_c     = (state != S_IDLE) || mul_busy;
  assign start_c    = wr_fire_c && hit_a2_c && !busy_c;
  assign coll_set_c = wr_fire_c && (hit_a1_c || hit_a2_c) && busy_c;
  assign pop_last_c = (state == S_POP) && (bit_idx == IDX_W'(DATA_W - 1));

  assign prod_ext_c  = EXT_W'(prod);
  assign w_new_c     = prod_ext_c[DATA_W-1:0];
  assign ovf_new_c   = |(prod_ext_c >> DATA_W);
  assign unused_hi_c = &{1'b0, sdata_in};

  gpioemu_shiftmul #(.OP_W(OP_W)) u_mul (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (start_c),
    .a       (a1_q),
    .b       (sdata_in[OP_W-1:0]),
    .busy    (mul_busy),
    .prod    (prod),
    .valid   (mul_valid)
  );

  // Status word and read-data mux
  always_comb begin
    status_c          = '0;
    status_c[ST_BUSY] = busy_c;
    status_c[ST_DONE] = done_q;
    status_c[ST_OVF]  = ovf_q;
    status_c[ST_COLL] = coll_q;
    rd_data_c         = '0;
    if (hit_a1_c)      rd_data_c = DATA_W'(a1_q);
    else if (hit_a2_c) rd_data_c = DATA_W'(a2_q);
    else if (hit_w_c)  rd_data_c = w_q;
    else if (hit_l_c)  rd_data_c = l_q;
    else if (hit_b_c)  rd_data_c = status_c;
    else if (hit_g_c)  rd_data_c = DATA_W'(gpio_in_s_insp);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= state_next;
  end

  // FSM next state: idle -> multiply -> popcount -> idle
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_c)    state_next = S_MUL;
      S_MUL:   if (mul_valid)  state_next = S_POP;
      S_POP:   if (pop_last_c) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bus registers, status flags, popcount datapath and gpio
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      srd_q          <= 1'b0;
      swr_q          <= 1'b0;
      a1_q           <= '0;
      a2_q           <= '0;
      w_q            <= '0;
      l_q            <= '0;
      w_work         <= '0;
      w_shift        <= '0;
      pop_cnt        <= '0;
      bit_idx        <= '0;
      done_q         <= 1'b0;
      ovf_q          <= 1'b0;
      coll_q         <= 1'b0;
      sdata_out      <= '0;
      gpio_out       <= '0;
      gpio_in_s_insp <= '0;
    end else begin
      srd_q <= srd;
      swr_q <= swr;
      if (gpio_latch) gpio_in_s_insp <= gpio_in;

      if (wr_fire_c && !busy_c) begin
        if (hit_a1_c) a1_q <= sdata_in[OP_W-1:0];
        if (hit_a2_c) a2_q <= sdata_in[OP_W-1:0];
      end

      if (rd_fire_c) sdata_out <= rd_data_c;

      // Read-to-clear first so a same-cycle completion still sets done
      if (rd_fire_c && hit_b_c) begin
        done_q <= 1'b0;
        coll_q <= 1'b0;
      end
      if (coll_set_c) coll_q <= 1'b1;
      if (start_c) begin
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end

      if (state == S_MUL && mul_valid) begin
        w_work  <= w_new_c;
        w_shift <= w_new_c;
        ovf_q   <= ovf_new_c;
        pop_cnt <= '0;
        bit_idx <= '0;
      end

      // Result is committed only at completion so busy reads see the old W/L
      if (state == S_POP) begin
        pop_cnt <= pop_cnt + POP_W'(w_shift[0]);
        w_shift <= w_shift >> 1;
        bit_idx <= bit_idx + IDX_W'(1);
        if (pop_last_c) begin
          w_q      <= w_work;
          l_q      <= DATA_W'(pop_cnt + POP_W'(w_shift[0]));
          done_q   <= 1'b1;
          gpio_out <= w_work[GPIO_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_gpioemu_seqmul.sv
// Directed self-checking bench for gpioemu_seqmul at default parameters.
module tb_gpioemu_seqmul;

  localparam logic [15:0] A_A1 = 16'h0108;
  localparam logic [15:0] A_A2 = 16'h0110;
  localparam logic [15:0] A_W  = 16'h0118;
  localparam logic [15:0] A_L  = 16'h0120;
  localparam logic [15:0] A_B  = 16'h0128;
  localparam logic [15:0] A_G  = 16'h0130;
  localparam logic [15:0] A_NA = 16'h0138;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] saddress;
  logic        srd, swr;
  logic [31:0] sdata_in, sdata_out;
  logic [31:0] gpio_in, gpio_out, gpio_in_s_insp;
  logic        gpio_latch;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_fire = 0;
  logic [31:0] rd, rd_gpio, st;

  gpioemu_seqmul dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_out       (gpio_out),
    .gpio_in_s_insp (gpio_in_s_insp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write strobe fires on the first edge; returns one idle cycle later
  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
    saddress = addr; sdata_in = data; swr = 1'b1;
    @(posedge clk); #1;
    last_fire = cyc; swr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
    saddress = addr; srd = 1'b1;
    @(posedge clk); #1;
    data = sdata_out; rd_gpio = gpio_out; srd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  // Load operands, start a job and poll B until busy clears
  task automatic run_job(input logic [31:0] a, input logic [31:0] b, output logic [31:0] status);
    int n;
    bus_write(A_A1, a);
    bus_write(A_A2, b);
    n = 0;
    status = 32'h1;
    while (status[0] && n < 100) begin
      bus_read(A_B, status);
      n++;
    end
    if (status[0]) begin
      total++; bad++;
      $display("FAIL poll_timeout: busy still set after %0d reads", n);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%08h expected 'h%08h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    if (sdata_out !== 32'h0) begin bad++; $display("FAIL rst_sdata_out: got 'h%08h expected 0", sdata_out); end
    total++;
    if (gpio_out !== 32'h0) begin bad++; $display("FAIL rst_gpio_out: got 'h%08h expected 0", gpio_out); end
    total++;
    if (gpio_in_s_insp !== 32'h0) begin bad++; $display("FAIL rst_insp: got 'h%08h expected 0", gpio_in_s_insp); end
    total++;
    bus_read(A_B, rd);
    if (rd !== 32'h0) begin bad++; $display("FAIL rst_B: got 'h%08h expected 0", rd); end
    total++;
    bus_read(A_W, rd);
    if (rd !== 32'h0) begin bad++; $display("FAIL rst_W: got 'h%08h expected 0", rd); end
    total++;
  endtask

  task automatic test_regs();
    bus_write(A_A1, 32'hABCDEF12);
    bus_read(A_A1, rd);
    if (rd !== 32'h00CDEF12) begin bad++; $display("FAIL a1_trunc: got 'h%08h expected 'h00CDEF12", rd); end
    total++;
    bus_read(A_NA, rd);
    if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_rd: got 'h%08h expected 0", rd); end
    total++;
    bus_write(A_W, 32'h1234);
    bus_read(A_W, rd);
    if (rd !== 32'h0) begin bad++; $display("FAIL ro_write: got 'h%08h expected 0", rd); end
    total++;
    gpio_in = 32'hA5A51234; gpio_latch = 1'b1;
    @(posedge clk); #1;
    gpio_latch = 1'b0; gpio_in = 32'h0;
    @(posedge clk); #1;
    if (gpio_in_s_insp !== 32'hA5A51234) begin bad++; $display("FAIL insp_hold: got 'h%08h expected 'hA5A51234", gpio_in_s_insp); end
    total++;
    bus_read(A_G, rd);
    if (rd !== 32'hA5A51234) begin bad++; $display("FAIL G_read: got 'h%08h expected 'hA5A51234", rd); end
    total++;
  endtask

  task automatic test_basic();
    run_job(32'd2, 32'd7, st);
    if (st !== 32'b0010) begin bad++; $display("FAIL t1_B: got 'h%08h expected 'h2", st); end
    total++;
    bus_read(A_B, rd);
    if (rd !== 32'h0) begin bad++; $display("FAIL t1_B2: got 'h%08h expected 0", rd); end
    total++;
    bus_read(A_W, rd);
    if (rd !== 32'hE) begin bad++; $display("FAIL t1_W: got 'h%08h expected 'hE", rd); end
    total++;
    bus_read(A_L, rd);
    if (rd !== 32'd3) begin bad++; $display("FAIL t1_L: got 'h%08h expected 3", rd); end
    total++;
  endtask

  task automatic test_zero();
    run_job(32'd7, 32'd2, st);
    bus_read(A_W, rd);
    if (rd !== 32'hE) begin bad++; $display("FAIL t2_W_swap: got 'h%08h expected 'hE", rd); end
    total++;
    run_job(32'd0, 32'd8, st);
    if (st !== 32'b0010) begin bad++; $display("FAIL t2_B: got 'h%08h expected 'h2", st); end
    total++;
    bus_read(A_W, rd);
    if (rd !== 32'h0) begin bad++; $display("FAIL t2_W: got 'h%08h expected 0", rd); end
    total++;
    bus_read(A_L, rd);
    if (rd !== 32'h0) begin bad++; $display("FAIL t2_L: got 'h%08h expected 0", rd); end
    total++;
  endtask

  task automatic test_mixed();
    run_job(32'hED, 32'hFA, st);
    if (st !== 32'b0010) begin bad++; $display("FAIL t3_B: got 'h%08h expected 'h2", st); end
    total++;
    if (gpio_out !== 32'hE772) begin bad++; $display("FAIL t3_gpio: got 'h%08h expected 'hE772", gpio_out); end
    total++;
    bus_read(A_W, rd);
    if (rd !== 32'hE772) begin bad++; $display("FAIL t3_W: got 'h%08h expected 'hE772", rd); end
    total++;
    bus_read(A_L, rd);
    if (rd !== 32'd10) begin bad++; $display("FAIL t3_L: got 'h%08h expected 10", rd); end
    total++;
  endtask

  task automatic test_overflow();
    run_job(32'hFFFFFF, 32'hFFFFFF, st);
    if (st !== 32'b0110) begin bad++; $display("FAIL t4_B: got 'h%08h expected 'h6", st); end
    total++;
    bus_read(A_B, rd);
    if (rd !== 32'b0100) begin bad++; $display("FAIL t4_B2: got 'h%08h expected 'h4", rd); end
    total++;
    bus_read(A_W, rd);
    if (rd !== 32'hFE000001) begin bad++; $display("FAIL t4_W: got 'h%08h expected 'hFE000001", rd); end
    total++;
    bus_read(A_L, rd);
    if (rd !== 32'd8) begin bad++; $display("FAIL t4_L: got 'h%08h expected 8", rd); end
    total++;
  endtask

  task automatic test_collision();
    int s;
    bus_write(A_A1, 32'd3);
    bus_write(A_A2, 32'd9);
    s = last_fire;
    bus_write(A_A1, 32'd5);
    bus_read(A_W, rd);
    if (rd !== 32'hFE000001) begin bad++; $display("FAIL t5_W_busy: got 'h%08h expected 'hFE000001", rd); end
    total++;
    wait_cyc(s + 55);
    bus_read(A_B, rd);
    if (rd !== 32'b1001) begin bad++; $display("FAIL t5_B_busy: got 'h%08h expected 'h9", rd); end
    total++;
    if (rd_gpio !== 32'hFE000001) begin bad++; $display("FAIL t5_gpio_early: got 'h%08h expected 'hFE000001", rd_gpio); end
    total++;
    if (gpio_out !== 32'h1B) begin bad++; $display("FAIL t5_gpio_at57: got 'h%08h expected 'h1B", gpio_out); end
    total++;
    bus_read(A_B, rd);
    if (rd !== 32'b0010) begin bad++; $display("FAIL t5_B_done: got 'h%08h expected 'h2", rd); end
    total++;
    bus_read(A_A1, rd);
    if (rd !== 32'd3) begin bad++; $display("FAIL t5_A1: got 'h%08h expected 3", rd); end
    total++;
    bus_read(A_W, rd);
    if (rd !== 32'h1B) begin bad++; $display("FAIL t5_W: got 'h%08h expected 'h1B", rd); end
    total++;
    bus_read(A_L, rd);
    if (rd !== 32'd4) begin bad++; $display("FAIL t5_L: got 'h%08h expected 4", rd); end
    total++;
  endtask

  task automatic test_mid_reset();
    int s;
    bus_write(A_A1, 32'd3);
    bus_write(A_A2, 32'd9);
    s = last_fire;
    wait_cyc(s + 10);
    n_reset = 1'b0;
    @(posedge clk); #1;
    n_reset = 1'b1;
    if (sdata_out !== 32'h0) begin bad++; $display("FAIL t6_sdata_out: got 'h%08h expected 0", sdata_out); end
    total++;
    if (gpio_out !== 32'h0) begin bad++; $display("FAIL t6_gpio: got 'h%08h expected 0", gpio_out); end
    total++;
    bus_read(A_B, rd);
    if (rd !== 32'h0) begin bad++; $display("FAIL t6_B: got 'h%08h expected 0", rd); end
    total++;
    bus_read(A_W, rd);
    if (rd !== 32'h0) begin bad++; $display("FAIL t6_W: got 'h%08h expected 0", rd); end
    total++;
    run_job(32'd5, 32'd4, st);
    if (st !== 32'b0010) begin bad++; $display("FAIL t6_B_job: got 'h%08h expected 'h2", st); end
    total++;
    bus_read(A_W, rd);
    if (rd !== 32'h14) begin bad++; $display("FAIL t6_W_job: got 'h%08h expected 'h14", rd); end
    total++;
    bus_read(A_L, rd);
    if (rd !== 32'd2) begin bad++; $display("FAIL t6_L_job: got 'h%08h expected 2", rd); end
    total++;
  endtask

  initial begin
    n_reset = 1'b0; saddress = '0; srd = 1'b0; swr = 1'b0;
    sdata_in = '0; gpio_in = '0; gpio_latch = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_regs();
    test_basic();
    test_zero();
    test_mixed();
    test_overflow();
    test_collision();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
